// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizing helpers for the two-master sram-like arbiter.
package sram_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_id_t;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

    localparam int OUTSTANDING_DEFAULT = 2;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// In-order FIFO of source ids for transactions accepted by the slave but not yet answered.
module sram_id_fifo
    import sram_arbiter_pkg::*;
#(
    parameter  int DEPTH = OUTSTANDING_DEFAULT,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  src_id_t          push_id,
    input  logic             pop,
    output src_id_t          head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    src_id_t          slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: it is only read while count says the slot is live.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Merges instruction and data sram-like masters onto one slave, data first,
// holding the grant while the slave stalls a request.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    // Lock FSM
    //   state     | meaning
    //   LOCK_NONE | free arbitration, data master has priority
    //   LOCK_INST | inst request pending on slave, grant held on inst
    //   LOCK_DATA | data request pending on slave, grant held on data

    localparam int CNT_W = cnt_width(OUTSTANDING);

    lock_state_t      lock_q;
    lock_state_t      lock_next;
    src_id_t          grant;
    logic             granted_req;
    logic             can_issue;
    logic             accept;
    logic             pop;
    src_id_t          head_id;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // Registered count, so a response this cycle frees a slot only from the next edge.
    assign can_issue = (fifo_count < CNT_W'(OUTSTANDING));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_q <= LOCK_NONE;
        else       lock_q <= lock_next;
    end

    always_comb begin
        lock_next = lock_q;
        grant     = data_sram_req ? SRC_DATA : SRC_INST;
        case (lock_q)
            LOCK_INST: grant = SRC_INST;
            LOCK_DATA: grant = SRC_DATA;
            default:   ;
        endcase
        granted_req = (grant == SRC_DATA) ? data_sram_req : inst_sram_req;
        mem_req     = granted_req && can_issue && !reset;
        if (mem_req && !mem_addr_ok)
            lock_next = (grant == SRC_DATA) ? LOCK_DATA : LOCK_INST;
        else if (mem_req && mem_addr_ok)
            lock_next = LOCK_NONE;
    end

    assign mem_wr    = (grant == SRC_DATA) ? data_sram_wr    : inst_sram_wr;
    assign mem_size  = (grant == SRC_DATA) ? data_sram_size  : inst_sram_size;
    assign mem_wstrb = (grant == SRC_DATA) ? data_sram_wstrb : inst_sram_wstrb;
    assign mem_addr  = (grant == SRC_DATA) ? data_sram_addr  : inst_sram_addr;
    assign mem_wdata = (grant == SRC_DATA) ? data_sram_wdata : inst_sram_wdata;

    assign accept            = mem_req && mem_addr_ok;
    assign inst_sram_addr_ok = accept && (grant == SRC_INST);
    assign data_sram_addr_ok = accept && (grant == SRC_DATA);

    assign pop               = mem_data_ok && !fifo_empty;
    assign inst_sram_data_ok = pop && (head_id == SRC_INST);
    assign data_sram_data_ok = pop && (head_id == SRC_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    sram_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept && !fifo_full),
        .push_id (grant),
        .pop     (pop),
        .head    (head_id),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomized checks of sram_arbiter against a queue-based reference model.
module tb_sram_arbiter;

    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_aok, inst_dok, data_aok, data_dok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: -1 = unlocked, 0 = inst, 1 = data; queue of outstanding source ids.
    int m_lock = -1;
    int m_q[$];

    logic        s_mem_req, s_inst_aok, s_data_aok, s_inst_dok, s_data_dok;
    logic [31:0] s_mem_addr, s_inst_rdata, s_data_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_req),
        .inst_sram_wr      (inst_wr),
        .inst_sram_size    (inst_size),
        .inst_sram_wstrb   (inst_wstrb),
        .inst_sram_addr    (inst_addr),
        .inst_sram_wdata   (inst_wdata),
        .inst_sram_addr_ok (inst_aok),
        .inst_sram_data_ok (inst_dok),
        .inst_sram_rdata   (inst_rdata),
        .data_sram_req     (data_req),
        .data_sram_wr      (data_wr),
        .data_sram_size    (data_size),
        .data_sram_wstrb   (data_wstrb),
        .data_sram_addr    (data_addr),
        .data_sram_wdata   (data_wdata),
        .data_sram_addr_ok (data_aok),
        .data_sram_data_ok (data_dok),
        .data_sram_rdata   (data_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, compare every output with the model, advance the model.
    task automatic step();
        int          g, head;
        logic        greq, e_req, e_pop;
        logic [31:0] e_addr, e_wdata;
        logic [6:0]  e_ctl;
        @(negedge clk);
        g      = (m_lock >= 0) ? m_lock : (data_req ? 1 : 0);
        greq   = g ? data_req : inst_req;
        e_req  = greq && (m_q.size() < OUT) && !reset;
        e_addr = g ? data_addr : inst_addr;
        e_wdata = g ? data_wdata : inst_wdata;
        e_ctl  = g ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb};
        e_pop  = mem_data_ok && (m_q.size() > 0);
        head   = (m_q.size() > 0) ? m_q[0] : -1;
        s_mem_req = mem_req;     s_mem_addr = mem_addr;
        s_inst_aok = inst_aok;   s_data_aok = data_aok;
        s_inst_dok = inst_dok;   s_data_dok = data_dok;
        s_inst_rdata = inst_rdata; s_data_rdata = data_rdata;
        chk("count", 32'(dut.u_id_fifo.count), 32'(m_q.size()));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), 32'(e_ctl));
        chk("inst_addr_ok", 32'(inst_aok), 32'(e_req && mem_addr_ok && g == 0));
        chk("data_addr_ok", 32'(data_aok), 32'(e_req && mem_addr_ok && g == 1));
        chk("inst_data_ok", 32'(inst_dok), 32'(e_pop && head == 0));
        chk("data_data_ok", 32'(data_dok), 32'(e_pop && head == 1));
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        if (e_pop) void'(m_q.pop_front());
        if (e_req && !mem_addr_ok) m_lock = g;
        else if (e_req && mem_addr_ok) begin
            m_lock = -1;
            m_q.push_back(g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_addr_ok", 32'({inst_aok, data_aok}), 32'd0);
        chk("rst_data_ok", 32'({inst_dok, data_dok}), 32'd0);
        chk("rst_count", 32'(dut.u_id_fifo.count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Simultaneous requests: data wins, inst follows when data drops.
        inst_req = 1; inst_addr = 32'h1c00_0040;
        data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_wdata = 32'hdead_beef;
        mem_addr_ok = 1;
        step();
        chk("both_data_aok", 32'(s_data_aok), 32'd1);
        chk("both_inst_aok", 32'(s_inst_aok), 32'd0);
        data_req = 0; data_wr = 0;
        step();
        chk("next_inst_aok", 32'(s_inst_aok), 32'd1);
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_00aa;
        step();
        chk("drain1_data_dok", 32'(s_data_dok), 32'd1);
        mem_rdata = 32'h0000_00bb;
        step();
        chk("drain2_inst_dok", 32'(s_inst_dok), 32'd1);
        mem_data_ok = 0;

        // Slave stall holds the grant on inst even when data arrives.
        inst_req = 1; inst_addr = 32'h1c00_0010;
        step();
        data_req = 1; data_addr = 32'h0000_3000;
        step();
        chk("lock_addr_c2", s_mem_addr, 32'h1c00_0010);
        step();
        chk("lock_addr_c3", s_mem_addr, 32'h1c00_0010);
        chk("lock_data_aok", 32'(s_data_aok), 32'd0);
        mem_addr_ok = 1;
        step();
        chk("lock_inst_aok", 32'(s_inst_aok), 32'd1);
        inst_req = 0;
        step();
        chk("after_lock_data_aok", 32'(s_data_aok), 32'd1);
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        step();
        step();
        mem_data_ok = 0;

        // In-order responses routed to their owners.
        inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
        step();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_1000;
        step();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_1111;
        step();
        chk("ord_inst_dok", 32'(s_inst_dok), 32'd1);
        chk("ord_inst_rdata", s_inst_rdata, 32'h1111_1111);
        mem_rdata = 32'h2222_2222;
        step();
        chk("ord_data_dok", 32'(s_data_dok), 32'd1);
        chk("ord_data_rdata", s_data_rdata, 32'h2222_2222);
        mem_data_ok = 0;

        // Outstanding limit.
        inst_req = 1; inst_addr = 32'h1c00_0100; mem_addr_ok = 1;
        step();
        step();
        step();
        chk("full_mem_req", 32'(s_mem_req), 32'd0);
        chk("full_inst_aok", 32'(s_inst_aok), 32'd0);
        mem_data_ok = 1; mem_rdata = 32'h3333_3333;
        step();
        chk("full_pop_same_cycle", 32'(s_mem_req), 32'd0);
        mem_data_ok = 0;
        step();
        chk("full_freed_mem_req", 32'(s_mem_req), 32'd1);

        // Async reset with two outstanding.
        mem_addr_ok = 0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(dut.u_id_fifo.count), 32'd0);
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_inst_aok", 32'(inst_aok), 32'd0);
        m_q.delete();
        m_lock = -1;
        @(posedge clk); #1;
        reset = 1'b0;
        inst_req = 0;

        // Stray response with nothing outstanding.
        mem_data_ok = 1; mem_rdata = 32'h4444_4444;
        step();
        chk("stray_inst_dok", 32'(s_inst_dok), 32'd0);
        chk("stray_data_dok", 32'(s_data_dok), 32'd0);
        chk("stray_count", 32'(dut.u_id_fifo.count), 32'd0);
        mem_data_ok = 0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            inst_req    = ($urandom_range(0, 99) < 60);
            data_req    = ($urandom_range(0, 99) < 50);
            inst_wr     = 1'($urandom_range(0, 1));
            data_wr     = 1'($urandom_range(0, 1));
            inst_size   = 2'($urandom_range(0, 2));
            data_size   = 2'($urandom_range(0, 2));
            inst_wstrb  = 4'($urandom);
            data_wstrb  = 4'($urandom);
            inst_addr   = $urandom;
            data_addr   = $urandom;
            inst_wdata  = $urandom;
            data_wdata  = $urandom;
            mem_addr_ok = ($urandom_range(0, 99) < 55);
            mem_data_ok = ($urandom_range(0, 99) < 40);
            mem_rdata   = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter OUTSTANDING, default 2, maximum number of accepted-but-unanswered slave transactions (1..4).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 inst_sram_req/wr  in  1/1  instruction master request and write flag.
REQ-005 inst_sram_size/wstrb  in  2/4  instruction master access size and byte strobes.
REQ-006 inst_sram_addr/wdata  in  32/32  instruction master address and write data.
REQ-007 inst_sram_addr_ok/data_ok  out  1/1  instruction master request-accepted and response pulses.
REQ-008 inst_sram_rdata  out  32  instruction master read data.
REQ-009 data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data master request fields, same meaning as REQ-004..006.
REQ-010 data_sram_addr_ok/data_ok/rdata  out  1/1/32  data master handshake and read data.
REQ-011 mem_req/wr/size/wstrb/addr/wdata  out  1/1/2/4/32/32  merged request to the shared sram-like slave.
REQ-012 mem_addr_ok/data_ok  in  1/1  slave accept and response pulses; responses in request order.
REQ-013 mem_rdata  in  32  slave read data, valid with mem_data_ok.

Function
REQ-014 Request fields on mem_* SHALL be taken from the granted master; rdata to both masters SHALL equal mem_rdata.
REQ-015 Grant: if lock set, the locked source; else data master if data_sram_req, else instruction master.
REQ-016 Lock SHALL set to the granted source when mem_req=1 and mem_addr_ok=0, and clear on a cycle with mem_req=1 and mem_addr_ok=1.
REQ-017 mem_req SHALL equal the granted master's req AND (count < OUTSTANDING).
REQ-018 Granted master's addr_ok SHALL equal mem_addr_ok AND mem_req; non-granted master's addr_ok SHALL be 0.
REQ-019 Accept (mem_req and mem_addr_ok) SHALL push the granted source id into an in-order id FIFO the same edge.
REQ-020 mem_data_ok with count>0 SHALL pop the FIFO head and assert data_ok only to the head source the same cycle (combinational).
REQ-021 mem_data_ok with count=0 SHALL be ignored: no pop, no master data_ok, count stays 0.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; pointers advance modulo OUTSTANDING.
REQ-023 Count=OUTSTANDING SHALL force mem_req=0 and both addr_ok=0 until a pop; a pop and new push are legal in the same cycle only from the next edge (full check uses registered count).
REQ-024 Latency: request to mem_req 0 cycles; response to master data_ok 0 cycles; no internal buffering of data.

Reset
REQ-025 Reset SHALL clear lock, FIFO pointers and count to 0 immediately, independent of clk.
REQ-026 During and after reset mem_req, all addr_ok and all data_ok SHALL be 0 until a new request arrives.
REQ-027 Reset mid-transaction SHALL discard outstanding ids; later stray mem_data_ok follows REQ-021.

Structure
REQ-028 Shared package SHALL hold the source-id type (SRC_INST=0, SRC_DATA=1) and default OUTSTANDING.
REQ-029 The id FIFO SHALL be a sub-module sram_id_fifo (push, pop, head, count, full, empty).
REQ-030 Arbitration and lock SHALL live in sram_arbiter; no other state.

Verification
REQ-031 Both req=1 same cycle, slave addr_ok=1 -> data accepted first (data addr_ok=1, inst addr_ok=0); inst accepted next cycle if data_req drops.
REQ-032 Inst req, slave holds addr_ok=0 for 3 cycles while data_req rises on cycle 2 -> grant stays inst; mem_addr stays inst address until addr_ok.
REQ-033 Accept inst 0x1c000000 then data 0x00001000, responses rdata 0x11111111 then 0x22222222 -> inst data_ok with 0x11111111, then data data_ok with 0x22222222.
REQ-034 OUTSTANDING=2, two accepts without response -> third request sees mem_req=0; after one mem_data_ok, mem_req=1 next cycle.
REQ-035 mem_data_ok pulsed with count=0 -> no master data_ok, count remains 0.
REQ-036 Assert reset asynchronously with 2 outstanding -> count=0, mem_req=0 before next clk edge.
